// File: rtl/mem_analog_delay.sv
// Fixed-point circular delay line: samples are realigned/saturated on entry,
// written on cke, and read back combinationally at a clamped tap.
module mem_analog_delay #(
  parameter int  DEPTH        = 8,
  parameter real init         = 0.0,
  parameter int  in_width     = 16,
  parameter int  in_exponent  = -12,
  parameter int  out_width    = 16,
  parameter int  out_exponent = -12,
  localparam int TW           = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW           = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cke,
  input  logic                        flush,
  input  logic signed [in_width-1:0]  in,
  input  logic        [TW-1:0]        tap,
  output logic signed [out_width-1:0] out,
  output logic                        out_valid,
  output logic        [CW-1:0]        count
);

  // Reset/flush value, resolved at elaboration: floor then saturate.
  localparam real init_scaled = $floor(init * (2.0 ** (-out_exponent)));
  localparam real out_max_r   = (2.0 ** (out_width - 1)) - 1.0;
  localparam real out_min_r   = -(2.0 ** (out_width - 1));
  localparam real init_sat    = (init_scaled > out_max_r) ? out_max_r :
                                (init_scaled < out_min_r) ? out_min_r : init_scaled;
  localparam logic signed [out_width-1:0] init_aligned = out_width'($rtoi(init_sat));

  localparam int lsh   = (in_exponent > out_exponent) ? (in_exponent - out_exponent) : 0;
  localparam int rsh   = (in_exponent < out_exponent) ? (out_exponent - in_exponent) : 0;
  localparam int ext_w = (((in_width + lsh) > out_width) ? (in_width + lsh) : out_width) + 1;

  localparam logic signed [ext_w-1:0] sat_max =
    {{(ext_w - out_width + 1){1'b0}}, {(out_width - 1){1'b1}}};
  localparam logic signed [ext_w-1:0] sat_min =
    {{(ext_w - out_width + 1){1'b1}}, {(out_width - 1){1'b0}}};

  localparam logic [TW:0]   depth_w = (TW + 1)'(DEPTH);
  localparam logic [TW-1:0] last_w  = TW'(DEPTH - 1);

  logic signed [ext_w-1:0]     in_ext;
  logic signed [ext_w-1:0]     in_shift;
  logic signed [out_width-1:0] in_aligned;

  logic signed [out_width-1:0] mem_q [DEPTH];
  logic signed [out_width-1:0] mem_d [DEPTH];
  logic        [TW-1:0]        wptr_q, wptr_d;
  logic        [CW-1:0]        count_q, count_d;

  logic [TW-1:0] tap_c;
  logic [TW:0]   idx_sum;
  logic [TW:0]   idx_mod;
  logic [TW-1:0] rd_idx;

  // Widened so the shift cannot lose sign or magnitude before saturation.
  always_comb begin
    in_ext   = {{(ext_w - in_width){in[in_width-1]}}, in};
    in_shift = (in_ext <<< lsh) >>> rsh;
    if (in_shift > sat_max) begin
      in_aligned = sat_max[out_width-1:0];
    end else if (in_shift < sat_min) begin
      in_aligned = sat_min[out_width-1:0];
    end else begin
      in_aligned = in_shift[out_width-1:0];
    end
  end

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = init_aligned;
      end
      wptr_d  = '0;
      count_d = '0;
    end else if (cke) begin
      mem_d[wptr_q] = in_aligned;
      wptr_d        = (wptr_q == last_w) ? '0 : wptr_q + 1'b1;
      count_d       = (count_q == CW'(DEPTH)) ? count_q : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= init_aligned;
      end
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // wptr points at the next free slot, so the newest sample sits at wptr-1.
  always_comb begin
    tap_c     = (tap > last_w) ? last_w : tap;
    idx_sum   = {1'b0, wptr_q} + depth_w - {1'b0, tap_c} - (TW + 1)'(1);
    idx_mod   = (idx_sum >= depth_w) ? idx_sum - depth_w : idx_sum;
    rd_idx    = idx_mod[TW-1:0];
    out_valid = 32'(count_q) > 32'(tap_c);
    out       = out_valid ? mem_q[rd_idx] : init_aligned;
  end

  assign count = count_q;

endmodule

// File: tb/tb_mem_analog_delay.sv
// Bench for mem_analog_delay: three configurations share one stimulus stream
// and are checked against a queue-based history model through a scoreboard.
module tb_mem_analog_delay;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cke = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] din = '0;
  logic [2:0]  tap = '0;

  logic [15:0] out_a, out_b, out_c;
  logic        v_a, v_b, v_c;
  logic [3:0]  cnt_a;
  logic [2:0]  cnt_b;
  logic [0:0]  cnt_c;

  int checks = 0;
  int errors = 0;

  // A: DEPTH 8, init 0.5, same formats. B: DEPTH 6, input 2^-8 into 2^-12.
  // C: DEPTH 1, init -0.3, input 2^-14 into 2^-12.
  mem_analog_delay #(.DEPTH(8), .init(0.5), .in_width(16), .in_exponent(-12),
                     .out_width(16), .out_exponent(-12)) dut_a (
    .clk(clk), .rst(rst), .cke(cke), .flush(flush), .in(din), .tap(tap),
    .out(out_a), .out_valid(v_a), .count(cnt_a));

  mem_analog_delay #(.DEPTH(6), .init(0.0), .in_width(16), .in_exponent(-8),
                     .out_width(16), .out_exponent(-12)) dut_b (
    .clk(clk), .rst(rst), .cke(cke), .flush(flush), .in(din), .tap(tap),
    .out(out_b), .out_valid(v_b), .count(cnt_b));

  mem_analog_delay #(.DEPTH(1), .init(-0.3), .in_width(16), .in_exponent(-14),
                     .out_width(16), .out_exponent(-12)) dut_c (
    .clk(clk), .rst(rst), .cke(cke), .flush(flush), .in(din), .tap(tap[0]),
    .out(out_c), .out_valid(v_c), .count(cnt_c));

  // ---------------- clock/reset block ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam int INIT_A = 2048;   // floor(0.5 * 4096)
  localparam int INIT_B = 0;
  localparam int INIT_C = -1229;  // floor(-0.3 * 4096) = floor(-1228.8)

  // Histories, newest sample at index 0.
  longint hist_a[$];
  longint hist_b[$];
  longint hist_c[$];

  typedef struct packed {
    logic [15:0] out_a; logic v_a; logic [3:0] cnt_a;
    logic [15:0] out_b; logic v_b; logic [2:0] cnt_b;
    logic [15:0] out_c; logic v_c; logic [0:0] cnt_c;
  } exp_t;

  exp_t exp_q[$];

  function automatic longint align(input logic [15:0] x, input int s);
    int     xi;
    real    r;
    longint v;
    xi = int'($signed(x));
    r  = real'(xi) * (2.0 ** s);
    v  = longint'($floor(r));
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return v;
  endfunction

  task automatic model_clear();
    hist_a.delete();
    hist_b.delete();
    hist_c.delete();
  endtask

  task automatic model_edge(input logic c, input logic f, input logic [15:0] x);
    if (f) begin
      model_clear();
    end else if (c) begin
      hist_a.push_front(align(x, 0));
      hist_b.push_front(align(x, 4));
      hist_c.push_front(align(x, -2));
      if (hist_a.size() > 8) hist_a.delete(hist_a.size() - 1);
      if (hist_b.size() > 6) hist_b.delete(hist_b.size() - 1);
      if (hist_c.size() > 1) hist_c.delete(hist_c.size() - 1);
    end
  endtask

  function automatic exp_t predict(input logic [2:0] tp);
    exp_t e;
    int ta, tb;
    ta = int'(tp);
    tb = (int'(tp) > 5) ? 5 : int'(tp);
    e.v_a   = ta < hist_a.size();
    e.out_a = e.v_a ? 16'(hist_a[ta]) : 16'(INIT_A);
    e.cnt_a = 4'(hist_a.size());
    e.v_b   = tb < hist_b.size();
    e.out_b = e.v_b ? 16'(hist_b[tb]) : 16'(INIT_B);
    e.cnt_b = 3'(hist_b.size());
    e.v_c   = hist_c.size() > 0;
    e.out_c = e.v_c ? 16'(hist_c[0]) : 16'(INIT_C);
    e.cnt_c = 1'(hist_c.size());
    return e;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic c, input logic f, input logic [15:0] x, input logic [2:0] tp);
    @(negedge clk);
    #1;
    cke = c; flush = f; din = x; tap = tp;
    @(posedge clk);
    #1;
    model_edge(c, f, x);
    exp_q.push_back(predict(tp));
  endtask

  // Reset asserted between edges; the monitor samples before any rising edge.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0; cke = 1'b0; flush = 1'b0;
    model_clear();
    exp_q.push_back(predict(tap));
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("a_out",   $signed(out_a), $signed(e.out_a));
        check("a_valid", {31'b0, v_a},   {31'b0, e.v_a});
        check("a_count", {28'b0, cnt_a}, {28'b0, e.cnt_a});
        check("b_out",   $signed(out_b), $signed(e.out_b));
        check("b_valid", {31'b0, v_b},   {31'b0, e.v_b});
        check("b_count", {29'b0, cnt_b}, {29'b0, e.cnt_b});
        check("c_out",   $signed(out_c), $signed(e.out_c));
        check("c_valid", {31'b0, v_c},   {31'b0, e.v_c});
        check("c_count", {31'b0, cnt_c}, {31'b0, e.cnt_c});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    logic [15:0] extremes [6];
    extremes = '{16'h007F, 16'h1000, 16'hF000, 16'hFFFF, 16'h7FFF, 16'h8000};

    do_reset();

    // Fill 1..5, then probe taps 0, 4, 5.
    for (int v = 1; v <= 5; v++) step(1'b1, 1'b0, 16'(v), 3'd0);
    step(1'b0, 1'b0, 16'd0, 3'd0);
    step(1'b0, 1'b0, 16'd0, 3'd4);
    step(1'b0, 1'b0, 16'd0, 3'd5);

    // Continue to 11 so both buffers wrap; tap 7 clamps to 5 on the 6-deep one.
    for (int v = 6; v <= 11; v++) step(1'b1, 1'b0, 16'(v), 3'd0);
    step(1'b0, 1'b0, 16'd0, 3'd7);
    step(1'b0, 1'b0, 16'd0, 3'd6);

    // flush together with cke drops the sample; sweep every tap.
    step(1'b1, 1'b1, 16'd9, 3'd0);
    for (int t = 0; t < 8; t++) step(1'b0, 1'b0, 16'd0, 3'(t));
    step(1'b1, 1'b0, 16'd7, 3'd0);

    // cke gating: delay is counted in cke events only.
    step(1'b0, 1'b1, 16'd0, 3'd0);
    for (int v = 1; v <= 3; v++) step(1'b1, 1'b0, 16'(v), 3'd1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'($urandom), 3'd1);
    step(1'b1, 1'b0, 16'd4, 3'd1);

    // Alignment and saturation corners.
    step(1'b0, 1'b1, 16'd0, 3'd0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, extremes[i], 3'd0);
    for (int t = 0; t < 8; t++) step(1'b0, 1'b0, 16'd0, 3'(t));

    // Reset mid-operation discards history.
    do_reset();
    step(1'b0, 1'b0, 16'd0, 3'd0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] x;
      x = ($urandom_range(0, 3) == 0) ? extremes[$urandom_range(0, 5)] : 16'($urandom);
      step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 39) == 0), x, 3'($urandom_range(0, 7)));
    end
    do_reset();

    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
